// File: rtl/sc_bin_counter.sv
// Stochastic-to-binary converter: counts 1s on a unipolar bitstream over 2**N_BITS cycles
// and presents the count with a valid/ready handshake. Define SC_CONT_CONV_EN for continuous mode.
module sc_bin_counter #(
    parameter int N_BITS = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            sn_in_i,
    output logic            busy_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N_BITS:0] out_count_o,
    output logic            overrun_o
);

    localparam logic [N_BITS-1:0] WIN_LAST = {N_BITS{1'b1}};
    localparam logic [N_BITS-1:0] WIN_ONE  = {{(N_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS:0]   ones_q, ones_d;
    logic [N_BITS:0]   count_q, count_d;
    logic [N_BITS-1:0] win_q, win_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [N_BITS:0]   ones_inc_s;

    // ones is one bit wider than the window index, so the full-window count never wraps
    assign ones_inc_s = ones_q + {{N_BITS{1'b0}}, sn_in_i};

    // Next-state and output logic for the IDLE/COUNT/HOLD sequencer
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        win_d     = win_q;
        count_d   = count_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COUNT;
                    ones_d  = '0;
                    win_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                state_d = S_COUNT;
                ones_d  = ones_inc_s;
                win_d   = win_q + WIN_ONE;
                if (win_q == WIN_LAST) begin
                    count_d = ones_inc_s;
                    valid_d = 1'b1;
`ifdef SC_CONT_CONV_EN
                    // Back-to-back windows: restart immediately, flag an unread result
                    ones_d = '0;
                    win_d  = '0;
                    if (valid_q && !out_ready_i) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
`else
                    state_d = S_HOLD;
`endif
                end else if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        state_d = S_COUNT;
                        ones_d  = '0;
                        win_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_COUNT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ones_q    <= '0;
            win_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            win_q     <= win_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy_o      = busy_q;
    assign out_valid_o = valid_q;
    assign out_count_o = count_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sc_bin_counter.sv
// Randomized scoreboard bench for sc_bin_counter (N_BITS=7, 128-sample windows).
module tb_sc_bin_counter;

    localparam int NB  = 7;
    localparam int WIN = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sn;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [NB:0]   out_count;
    logic          overrun;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    sc_bin_counter #(.N_BITS(NB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .sn_in_i    (sn),
        .busy_o     (busy),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_count_o(out_count),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: a handshake seen at the falling edge is taken on the next rising edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0d expected none", out_count);
            end else begin
                chk("scoreboard_count", {24'd0, out_count}, exp_q.pop_front());
            end
        end
    end

    function automatic bit pick(input int mode, input int i);
        case (mode)
            0:       pick = 1'b0;
            1:       pick = 1'b1;
            2:       pick = (i % 2 == 0);
            default: pick = ($urandom_range(0, 99) < mode * 7);
        endcase
    endfunction

    // One single-shot window: the expected count is the number of 1s in the
    // 128 samples that follow the start edge
    task automatic run_window(input int mode, input bit hold_start);
        bit bits[WIN];
        int sum = 0;
        for (int i = 0; i < WIN; i++) begin
            bits[i] = pick(mode, i);
            sum += int'(bits[i]);
        end
        exp_q.push_back(sum);
        start = 1'b1;
        sn    = 1'($urandom_range(0, 1));
        cyc();
        start = hold_start;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < WIN; i++) begin
            sn = bits[i];
            if (i == WIN - 1) chk("valid_before_last", {31'd0, out_valid}, 32'd0);
            cyc();
        end
        chk("valid_at_done", {31'd0, out_valid}, 32'd1);
        start = 1'b0;
    endtask

    initial begin
        bit bits[WIN];
        int sum;
        rst_n = 1'b0; start = 1'b0; sn = 1'b0; out_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {24'd0, out_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        cyc();
`ifndef SC_CONT_CONV_EN
        out_ready = 1'b1;
        run_window(1, 1'b0);
        chk("busy_in_hold", {31'd0, busy}, 32'd0);
        cyc();
        chk("idle_after_accept", {31'd0, busy}, 32'd0);
        chk("valid_after_accept", {31'd0, out_valid}, 32'd0);
        run_window(0, 1'b0); cyc();
        run_window(2, 1'b0); cyc();
        for (int k = 3; k < 14; k += 5) begin
            run_window(k, 1'b0);
            cyc();
        end
        // start held high throughout the window: exactly one result, no restart
        run_window(6, 1'b1);
        cyc();
        chk("held_start_idle", {31'd0, busy}, 32'd0);
        repeat (5) cyc();
        chk("held_start_no_rerun", {31'd0, out_valid}, 32'd0);
        // consumer stalls 20 cycles: result and flags stay frozen
        out_ready = 1'b0;
        run_window(2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_count", {24'd0, out_count}, 32'd64);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end
        out_ready = 1'b1;
        run_window(1, 1'b0);
        cyc();
        // reset in the middle of a window
        start = 1'b1; sn = 1'b1;
        cyc();
        start = 1'b0;
        repeat (50) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_count", {24'd0, out_count}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        cyc();
        run_window(1, 1'b0);
        cyc();
        run_window(9, 1'b0);
        cyc();
        chk("overrun_tied_low", {31'd0, overrun}, 32'd0);
`else
        out_ready = 1'b1;
        start = 1'b1; sn = 1'b1;
        cyc();
        start = 1'b0;
        chk("cont_busy", {31'd0, busy}, 32'd1);
        for (int w = 0; w < 3; w++) begin
            sum = 0;
            for (int i = 0; i < WIN; i++) begin
                bits[i] = pick(w + 2, i);
                sum += int'(bits[i]);
            end
            exp_q.push_back(sum);
            for (int i = 0; i < WIN; i++) begin
                sn = bits[i];
                cyc();
            end
            chk("cont_valid", {31'd0, out_valid}, 32'd1);
            chk("cont_no_overrun", {31'd0, overrun}, 32'd0);
            chk("cont_busy_kept", {31'd0, busy}, 32'd1);
        end
        // stop accepting: first all-ones result waits, the second overwrites it
        for (int i = 0; i < WIN; i++) begin
            sn = 1'b1;
            cyc();
            if (i == 0) out_ready = 1'b0;
        end
        chk("cont_first_unread", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < WIN; i++) begin
            sn = 1'b1;
            cyc();
        end
        chk("cont_overrun", {31'd0, overrun}, 32'd1);
        chk("cont_overrun_count", {24'd0, out_count}, 32'd128);
        exp_q.push_back(WIN);
        out_ready = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("cont_rst_overrun", {31'd0, overrun}, 32'd0);
`endif
        repeat (3) cyc();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
